// File: rtl/arb_report_pkg.sv
// Shared types and constants for the trade report scheduler (FSM states, frame type codes, framing bytes).
// Latency: none (declarations only).
// Backpressure: none. Build option REPORT_CHECKSUM_EN selects frame lengths with a checksum byte.
package arb_report_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_ACK    = 2'd2,
    ST_DRAIN  = 2'd3
  } sched_state_t;

  localparam logic [7:0] FRAME_TYPE_TRADE  = 8'h01;
  localparam logic [7:0] FRAME_TYPE_HB     = 8'h02;
  localparam logic [7:0] DEFAULT_FRAME_HDR = 8'hAA;
  localparam logic [7:0] DEFAULT_FRAME_FTR = 8'h55;

`ifdef REPORT_CHECKSUM_EN
  localparam int unsigned TRADE_FRAME_LEN = 7;
  localparam int unsigned HB_FRAME_LEN    = 5;
`else
  localparam int unsigned TRADE_FRAME_LEN = 6;
  localparam int unsigned HB_FRAME_LEN    = 4;
`endif

endpackage

// File: rtl/heartbeat_timer.sv
// Free-running period counter: counts 0..CYCLES-1 and pulses tick while at the wrap value.
// Latency: tick is decoded from the counter, high for exactly one cycle per period.
// Backpressure: none; the counter never stalls.
module heartbeat_timer #(
  parameter int unsigned CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CYCLES - 1));

  // Count up, wrapping to zero on the cycle the tick is raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/trade_report_scheduler.sv
// Serialises trade reports and periodic heartbeats into byte frames for a UART (REPORT_CHECKSUM_EN adds a checksum byte).
// Latency: trade_valid in cycle N gives tx_en with the header byte in cycle N+2 when idle and the UART is free.
// Backpressure: each byte waits for tx_busy low; one pending trade slot, overwrites counted in drop_count.
module trade_report_scheduler
  import arb_report_pkg::*;
#(
  parameter int unsigned HEARTBEAT_CYCLES = 50_000_000,
  parameter logic [7:0]  FRAME_HDR        = DEFAULT_FRAME_HDR,
  parameter logic [7:0]  FRAME_FTR        = DEFAULT_FRAME_FTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trade_valid,
  input  logic [15:0] profit,
  input  logic [1:0]  trade_action,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        sched_busy,
  output logic [7:0]  drop_count
);

  sched_state_t state;

  logic        pending;
  logic [15:0] pend_profit;
  logic [1:0]  pend_action;
  logic        hb_pending;
  logic        hb_tick;
  logic [7:0]  hb_seq;

  // Shadow of the frame in flight, so later trade_valid pulses cannot disturb it.
  logic        sh_is_hb;
  logic [15:0] sh_profit;
  logic [1:0]  sh_action;
  logic [7:0]  sh_seq;

  logic [2:0]  byte_idx;
  logic [2:0]  last_idx;
  logic [7:0]  frame [8];

  logic take_trade;
  logic take_hb;

  // Trades win over heartbeats whenever both are waiting in IDLE.
  assign take_trade = (state == ST_IDLE) && pending;
  assign take_hb    = (state == ST_IDLE) && !pending && hb_pending;

  // Decoded from state so the header strobe lands two cycles after trade_valid.
  assign tx_en = (state == ST_STROBE) && !tx_busy;

  heartbeat_timer #(
    .CYCLES (HEARTBEAT_CYCLES)
  ) u_heartbeat_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (hb_tick)
  );

  // Lay out the in-flight frame byte by byte from the shadow registers.
  always_comb begin
    for (int i = 0; i < 8; i++) frame[i] = 8'h00;
    last_idx = 3'(TRADE_FRAME_LEN - 1);
    if (sh_is_hb) begin
      last_idx = 3'(HB_FRAME_LEN - 1);
      frame[0] = FRAME_HDR;
      frame[1] = FRAME_TYPE_HB;
      frame[2] = sh_seq;
`ifdef REPORT_CHECKSUM_EN
      frame[3] = FRAME_TYPE_HB ^ sh_seq;
      frame[4] = FRAME_FTR;
`else
      frame[3] = FRAME_FTR;
`endif
    end else begin
      frame[0] = FRAME_HDR;
      frame[1] = FRAME_TYPE_TRADE;
      frame[2] = {6'b0, sh_action};
      frame[3] = sh_profit[15:8];
      frame[4] = sh_profit[7:0];
`ifdef REPORT_CHECKSUM_EN
      frame[5] = FRAME_TYPE_TRADE ^ {6'b0, sh_action} ^ sh_profit[15:8] ^ sh_profit[7:0];
      frame[6] = FRAME_FTR;
`else
      frame[5] = FRAME_FTR;
`endif
    end
  end

  // Single pending trade slot; a pulse that lands while the slot is full and not being taken counts as a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      pend_profit <= '0;
      pend_action <= '0;
      drop_count  <= '0;
    end else if (trade_valid) begin
      pending     <= 1'b1;
      pend_profit <= profit;
      pend_action <= trade_action;
      if (pending && !take_trade && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (take_trade) begin
      pending <= 1'b0;
    end
  end

  // Heartbeat request: set on each timer wrap, cleared when its frame starts (a new wrap wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_pending <= 1'b0;
    end else if (hb_tick) begin
      hb_pending <= 1'b1;
    end else if (take_hb) begin
      hb_pending <= 1'b0;
    end
  end

  // Frame sequencer: latch a frame, then strobe / wait for busy to rise / wait for busy to fall per byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_data    <= 8'h00;
      sched_busy <= 1'b0;
      byte_idx   <= '0;
      sh_is_hb   <= 1'b0;
      sh_profit  <= '0;
      sh_action  <= '0;
      sh_seq     <= '0;
      hb_seq     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_trade || take_hb) begin
            sh_is_hb   <= take_hb;
            sh_profit  <= pend_profit;
            sh_action  <= pend_action;
            sh_seq     <= hb_seq;
            byte_idx   <= '0;
            tx_data    <= FRAME_HDR;
            sched_busy <= 1'b1;
            state      <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (!tx_busy) state <= ST_ACK;
        end
        ST_ACK: begin
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            if (byte_idx == last_idx) begin
              state      <= ST_IDLE;
              sched_busy <= 1'b0;
              if (sh_is_hb) hb_seq <= hb_seq + 8'd1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              tx_data  <= frame[byte_idx + 3'd1];
              state    <= ST_STROBE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/trade_report_scheduler.md
TRADE_REPORT_SCHEDULER -- requirements
Module: trade_report_scheduler

Interface
REQ-001 SHALL have parameter HEARTBEAT_CYCLES, default 50_000_000, heartbeat period in clk cycles (1 s at 50 MHz).
REQ-002 SHALL have parameter FRAME_HDR, default 8'hAA, first byte of every frame.
REQ-003 SHALL have parameter FRAME_FTR, default 8'h55, last byte of every frame.
REQ-004 SHALL have ports as follows; one clock; reset asynchronous, active-high:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous active-high reset.
- trade_valid  in  1  one-cycle strobe marking new profit/trade_action.
- profit  in  16  unsigned profit in cents.
- trade_action  in  2  trade decision code.
- tx_busy  in  1  UART transmitter busy.
- tx_en  out  1  one-cycle strobe starting one UART byte.
- tx_data  out  8  byte to transmit; valid while tx_en=1.
- sched_busy  out  1  high while a frame is in flight.
- drop_count  out  8  saturating count of overwritten trade reports.

Function
REQ-005 SHALL send trade frames: FRAME_HDR, 8'h01, {6'b0,action}, profit[15:8], profit[7:0], checksum, FRAME_FTR.
REQ-006 SHALL send heartbeat frames: FRAME_HDR, 8'h02, hb_seq, checksum, FRAME_FTR.
REQ-007 SHALL compute checksum as the XOR of all bytes between header and checksum.
REQ-008 SHALL hold one pending trade entry: trade_valid loads profit/action into it and sets pending.
REQ-009 SHALL, on trade_valid while pending is set and not consumed that cycle, overwrite the entry and increment drop_count (saturates at 8'hFF).
REQ-010 SHALL treat trade_valid in the same cycle IDLE consumes pending as a fresh pending entry with no drop.
REQ-011 SHALL copy the pending entry into a shadow register at frame start; later overwrites SHALL NOT alter the in-flight frame.
REQ-012 SHALL count free-running to HEARTBEAT_CYCLES-1, wrap to 0, and set hb_pending at the wrap; hb_pending clears when the heartbeat frame starts.
REQ-013 SHALL give trade frames strict priority over heartbeats when both are pending in IDLE.
REQ-014 SHALL implement FSM IDLE->STROBE->ACK->DRAIN->(STROBE for next byte | IDLE after footer).
REQ-015 IDLE: if pending or hb_pending, latch frame, byte index 0, go STROBE.
REQ-016 STROBE: when tx_busy=0, assert tx_en for exactly one cycle with tx_data, go ACK; otherwise stay.
REQ-017 ACK: wait exactly one cycle (transmitter raises tx_busy by then), go DRAIN.
REQ-018 DRAIN: when tx_busy=0, advance byte index, go STROBE, or IDLE after footer.
REQ-019 SHALL give latency trade_valid at cycle N (idle, tx_busy=0) -> tx_en with tx_data=FRAME_HDR at cycle N+2.
REQ-020 hb_seq SHALL increment after each heartbeat frame, wrapping 8'hFF->8'h00.
REQ-021 sched_busy SHALL be high in every state except IDLE.

Reset
REQ-022 rst SHALL asynchronously force IDLE, tx_en=0, tx_data=8'h00, sched_busy=0, drop_count=0, pending=0, hb_pending=0, hb_seq=0, heartbeat counter=0.
REQ-023 Reset mid-frame SHALL abandon the frame; nothing is resent after release.

Configuration
REQ-024 With REPORT_CHECKSUM_EN defined: checksum byte SHALL be sent (trade frame 7 bytes, heartbeat 5).
REQ-025 Without REPORT_CHECKSUM_EN: checksum byte SHALL be omitted (trade frame 6 bytes, heartbeat 4); otherwise identical.

Structure
REQ-026 Package arb_report_pkg SHALL hold FSM state typedef, frame type codes 8'h01/8'h02, default header/footer constants.
REQ-027 Heartbeat counter SHALL be sub-module heartbeat_timer (outputs one-cycle tick).

Verification
REQ-028 profit=16'h0023, action=2'b01, checksum enabled -> bytes AA 01 01 00 23 23 55; first tx_en 2 cycles after trade_valid.
REQ-029 HEARTBEAT_CYCLES=1000, no trades -> at first wrap, AA 02 00 02 55; second heartbeat has hb_seq=01, checksum 03.
REQ-030 Three trade_valid pulses during one in-flight frame -> drop_count=2; next frame carries the third values; in-flight frame unchanged.
REQ-031 Trade and heartbeat both pending at IDLE -> trade frame fully sent first, then heartbeat frame.
REQ-032 rst asserted during profit-hi byte -> tx_en=0, sched_busy=0 immediately; no bytes after release until new trade_valid.
REQ-033 Built without REPORT_CHECKSUM_EN, same stimulus as REQ-028 -> AA 01 01 00 23 55.
